// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock-enable divider.
package clkdiv_pkg;

  localparam int DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  // The result is one bit wider than the divisor, so it cannot overflow at the largest divisor.
  function automatic logic [DIV_W:0] half_ceil(input div_t d);
    half_ceil = ({1'b0, d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_req_reg.sv
// Divisor request register: accepts one divisor over valid/ready and holds it until the
// switch boundary clears it.
module clkdiv_req_reg
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_bits,
  input  logic             clear,
  output logic             div_ready,
  output logic [WIDTH-1:0] pend_div,
  output logic             pending
);

  logic [WIDTH-1:0] coerced;

  // A zero divisor is mapped to 1 so that the counter always has a legal terminal count.
  always_comb begin
    if (div_bits == {WIDTH{1'b0}}) begin
      coerced = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      coerced = div_bits;
    end
  end

  // Pending request storage. Clear and accept never coincide, because accept requires that
  // no request is pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_div <= {WIDTH{1'b0}};
    end else if (clear) begin
      pending  <= 1'b0;
    end else if (div_valid && !pending) begin
      pending  <= 1'b1;
      pend_div <= coerced;
    end
  end

  assign div_ready = !pending;

endmodule

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable clock-enable generator. It produces a tick and a duty-cycle phase, and
// switches to a new divisor only on a period boundary.
module programmable_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_div_valid,
  output logic             io_div_ready,
  input  logic [WIDTH-1:0] io_div_bits,
  output logic             io_tick,
  output logic             io_phase,
  output logic [WIDTH-1:0] io_cur_div,
  output logic             io_switching
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cur_div;
  logic [WIDTH-1:0] pend_div;
  logic             pending;
  logic             last;
  logic             do_switch;
  logic [WIDTH:0]   half;

  assign last      = (cnt == (cur_div - ONE));
  assign do_switch = last && pending;

  clkdiv_req_reg #(.WIDTH(WIDTH)) u_req (
    .clock     (clock),
    .reset     (reset),
    .div_valid (io_div_valid),
    .div_bits  (io_div_bits),
    .clear     (do_switch),
    .div_ready (io_div_ready),
    .pend_div  (pend_div),
    .pending   (pending)
  );

  generate
    if (WIDTH == DIV_W) begin : g_pkg_half
      assign half = half_ceil(cur_div);
    end else begin : g_gen_half
      assign half = ({1'b0, cur_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    end
  endgenerate

  // Period counter and active divisor. A new divisor is loaded only on the final cycle of a
  // period, so no partial period is ever emitted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= {WIDTH{1'b0}};
      cur_div <= RESET_VAL;
    end else if (do_switch) begin
      cnt     <= {WIDTH{1'b0}};
      cur_div <= pend_div;
    end else if (last) begin
      cnt     <= {WIDTH{1'b0}};
    end else begin
      cnt     <= cnt + ONE;
    end
  end

  assign io_tick      = (cnt == {WIDTH{1'b0}});
  assign io_phase     = ({1'b0, cnt} < half);
  assign io_cur_div   = cur_div;
  assign io_switching = pending;

endmodule
